// File: rtl/adaptive_tap_buffer.sv
// Circular-buffer delay line for the adaptive filter: writes one sample per handshake
// into external RAM, then streams the newest TAPS samples (newest first) to the MAC.
module adaptive_tap_buffer #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TAPS       = 32,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wr_data,
  output logic                      ram_wr_en,
  input  logic [DATA_WIDTH-1:0]     ram_rd_data,
  output logic [DATA_WIDTH-1:0]     tap_data,
  output logic                      tap_valid,
  output logic [$clog2(TAPS)-1:0]   tap_idx,
  output logic                      tap_last,
  output logic                      busy
);

  localparam int unsigned TAP_W = $clog2(TAPS);
  localparam int unsigned CNT_W = TAP_W + 1;
  localparam int unsigned DRN_W = $clog2(RD_LATENCY + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [TAP_W-1:0]      rd_k;
  logic [DRN_W-1:0]      drn_cnt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [CNT_W-1:0]      fill_cnt;

  // Read-side pipe, stage 0 aligned with the address currently on ram_addr
  logic [RD_LATENCY-1:0]            pipe_vld;
  logic [RD_LATENCY-1:0]            pipe_zero;
  logic [RD_LATENCY-1:0][TAP_W-1:0] pipe_k;

  logic                  handshake;
  logic                  last_rd;
  logic                  drn_done;
  logic                  issue;
  logic [TAP_W-1:0]      issue_k;
  logic                  issue_zero;
  logic [ADDR_WIDTH-1:0] issue_addr;

  assign handshake  = in_valid && in_ready;
  assign last_rd    = (rd_k == TAP_W'(TAPS - 1));
  assign drn_done   = (drn_cnt == DRN_W'(RD_LATENCY - 1));
  assign issue      = (state == S_WRITE) || ((state == S_READ) && !last_rd);
  assign issue_k    = (state == S_WRITE) ? '0 : rd_k + TAP_W'(1);
  assign issue_zero = (CNT_W'(issue_k) >= fill_cnt);
  assign issue_addr = wr_ptr - ADDR_WIDTH'(issue_k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (handshake) state_next = S_WRITE;
        S_WRITE: state_next = S_READ;
        S_READ:  if (last_rd) state_next = S_DRAIN;
        S_DRAIN: if (drn_done) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      rd_k        <= '0;
      drn_cnt     <= '0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      ram_wr_en   <= 1'b0;
      pipe_vld    <= '0;
      pipe_zero   <= '0;
      pipe_k      <= '0;
      tap_data    <= '0;
      tap_valid   <= 1'b0;
      tap_idx     <= '0;
      tap_last    <= 1'b0;
    end else begin
      in_ready <= (state_next == S_IDLE);
      busy     <= (state_next != S_IDLE);
      if (clr) begin
        wr_ptr    <= '0;
        fill_cnt  <= '0;
        rd_k      <= '0;
        drn_cnt   <= '0;
        ram_wr_en <= 1'b0;
        pipe_vld  <= '0;
        tap_valid <= 1'b0;
        tap_last  <= 1'b0;
      end else begin
        ram_wr_en <= (state == S_IDLE) && handshake;
        if ((state == S_IDLE) && handshake) begin
          ram_addr    <= wr_ptr;
          ram_wr_data <= in_data;
          if (fill_cnt != CNT_W'(TAPS)) fill_cnt <= fill_cnt + CNT_W'(1);
        end
        if (issue) begin
          ram_addr <= issue_addr;
          rd_k     <= issue_k;
        end
        drn_cnt <= (state == S_DRAIN) ? drn_cnt + DRN_W'(1) : '0;
        if ((state == S_DRAIN) && drn_done) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);

        pipe_vld[0]  <= issue;
        pipe_zero[0] <= issue_zero;
        pipe_k[0]    <= issue_k;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
          pipe_vld[i]  <= pipe_vld[i-1];
          pipe_zero[i] <= pipe_zero[i-1];
          pipe_k[i]    <= pipe_k[i-1];
        end

        // Taps beyond the fill level are masked to zero to hide stale RAM words
        tap_valid <= pipe_vld[RD_LATENCY-1];
        tap_last  <= pipe_vld[RD_LATENCY-1] && (pipe_k[RD_LATENCY-1] == TAP_W'(TAPS - 1));
        if (pipe_vld[RD_LATENCY-1]) begin
          tap_idx  <= pipe_k[RD_LATENCY-1];
          tap_data <= pipe_zero[RD_LATENCY-1] ? '0 : ram_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_adaptive_tap_buffer.sv
// Bench for adaptive_tap_buffer: RAM model plus a sample-history reference model,
// checked every cycle of every transaction.
module tb_adaptive_tap_buffer;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 16;
  localparam int unsigned TAPS  = 32;
  localparam int unsigned RDL   = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned TW    = $clog2(TAPS);

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_en;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] tap_data;
  logic          tap_valid;
  logic [TW-1:0] tap_idx;
  logic          tap_last;
  logic          busy;

  int unsigned n_chk;
  int unsigned n_pass;
  int unsigned n_fail;

  logic [DW-1:0] hist[$];
  int unsigned   n_wr;

  adaptive_tap_buffer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAPS(TAPS), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_data(ram_rd_data),
    .tap_data(tap_data), .tap_valid(tap_valid), .tap_idx(tap_idx),
    .tap_last(tap_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: contents seeded with nonzero junk; read data follows the address by one edge
  bit [DW-1:0] mem [DEPTH];
  bit          seeded;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DW'($urandom | 1);
      seeded <= 1'b1;
    end else if (ram_wr_en) begin
      mem[ram_addr] <= ram_wr_data;
    end
    ram_rd_data <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_tap(input int k);
    if (k < hist.size()) return hist[hist.size() - 1 - k];
    return '0;
  endfunction

  function automatic int unsigned addr_back(input int unsigned wp, input int k);
    return (wp + DEPTH - int'(k)) % DEPTH;
  endfunction

  // Starts at the negedge of an idle cycle T; returns at the negedge of T+TAPS+4
  task automatic run_sample(input logic [DW-1:0] s, input bit keep);
    int unsigned wp;
    int k;
    in_data  = s;
    in_valid = 1'b1;
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    wp = n_wr % DEPTH;
    n_wr++;
    hist.push_back(s);
    if (hist.size() > TAPS) void'(hist.pop_front());
    for (int c = 1; c <= int'(TAPS) + 3; c++) begin
      @(negedge clk);
      if (keep) in_data = DW'($urandom);
      else      in_valid = 1'b0;
      chk("busy", 32'(busy), 32'd1);
      chk("ready_low", 32'(in_ready), 32'd0);
      if (c == 1) begin
        chk("wr_en", 32'(ram_wr_en), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'(wp));
        chk("wr_data", 32'(ram_wr_data), 32'(s));
      end else begin
        chk("no_wr", 32'(ram_wr_en), 32'd0);
      end
      if (c >= 2 && c <= int'(TAPS) + 1)
        chk("rd_addr", 32'(ram_addr), 32'(addr_back(wp, c - 2)));
      k = c - 4;
      if (k >= 0) begin
        chk("tap_valid", 32'(tap_valid), 32'd1);
        chk("tap_idx", 32'(tap_idx), 32'(k));
        chk("tap_data", 32'(tap_data), 32'(exp_tap(k)));
        chk("tap_last", 32'(tap_last), (k == int'(TAPS) - 1) ? 32'd1 : 32'd0);
      end else begin
        chk("tap_idle", 32'(tap_valid), 32'd0);
        chk("tap_last_idle", 32'(tap_last), 32'd0);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hCAFE;
    @(negedge clk);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_wr_en", 32'(ram_wr_en), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    clr      = 1'b0;
    in_valid = 1'b0;
    hist.delete();
    n_wr = 0;
  endtask

  // Aborts a transaction during READ k=10 via clr or an rst_n pulse
  task automatic abort_sample(input logic [DW-1:0] s, input bit use_rst);
    int unsigned wp;
    in_data  = s;
    in_valid = 1'b1;
    chk("ab_ready", 32'(in_ready), 32'd1);
    wp = n_wr % DEPTH;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("ab_rd_addr10", 32'(ram_addr), 32'(addr_back(wp, 10)));
    if (!use_rst) begin
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      @(negedge clk);
      chk("ab_clr_tv", 32'(tap_valid), 32'd0);
      chk("ab_clr_tl", 32'(tap_last), 32'd0);
      chk("ab_clr_ready", 32'(in_ready), 32'd1);
      chk("ab_clr_busy", 32'(busy), 32'd0);
      chk("ab_clr_wr", 32'(ram_wr_en), 32'd0);
      @(negedge clk);
      chk("ab_clr_noacc_wr", 32'(ram_wr_en), 32'd0);
      chk("ab_clr_noacc_busy", 32'(busy), 32'd0);
      clr      = 1'b0;
      in_valid = 1'b0;
    end else begin
      rst_n = 1'b0;
      #1;
      chk("ab_rst_tv", 32'(tap_valid), 32'd0);
      chk("ab_rst_ready", 32'(in_ready), 32'd1);
      chk("ab_rst_busy", 32'(busy), 32'd0);
      chk("ab_rst_wr", 32'(ram_wr_en), 32'd0);
      chk("ab_rst_addr", 32'(ram_addr), 32'd0);
      @(negedge clk);
      chk("ab_rst_wr2", 32'(ram_wr_en), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ab_post_wr", 32'(ram_wr_en), 32'd0);
      chk("ab_post_ready", 32'(in_ready), 32'd1);
      chk("ab_post_tv", 32'(tap_valid), 32'd0);
    end
    hist.delete();
    n_wr = 0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0; n_wr = 0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 16'h5555;

    // Reset held with in_valid asserted
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
      chk("rst_tap_valid", 32'(tap_valid), 32'd0);
      chk("rst_tap_last", 32'(tap_last), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // First sample: tap 0 live, rest zero-filled over junk RAM
    run_sample(16'h1234, 1'b0);

    // Back-to-back ramp
    do_clear();
    for (int i = 1; i <= 40; i++) run_sample(DW'(i), 1'b1);
    in_valid = 1'b0;

    // Pointer wrap past the end of the buffer
    do_clear();
    for (int i = 0; i < 515; i++) run_sample(DW'(i), 1'b0);

    // Continuous in_valid with churning data
    for (int i = 0; i < 6; i++) run_sample(DW'($urandom), 1'b1);
    in_valid = 1'b0;

    // Mid-read abort by clr, then by reset
    abort_sample(16'h0A0A, 1'b0);
    run_sample(16'hBEEF, 1'b0);
    abort_sample(16'h0B0B, 1'b1);
    run_sample(16'hBEEF, 1'b0);

    chk("end_ready", 32'(in_ready), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
